// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: three sources share the register-file write port, with a same-cycle grant and a registered write.
// Define WB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 (PTR held at 0); round-robin otherwise.
module wb_arbiter #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          CLK_WB,
  input  logic          RESET,
  input  logic          STALL,
  input  logic          REQ_0,
  input  logic          REQ_1,
  input  logic          REQ_2,
  input  logic [AW-1:0] NREG_0,
  input  logic [AW-1:0] NREG_1,
  input  logic [AW-1:0] NREG_2,
  input  logic [DW-1:0] DATA_0,
  input  logic [DW-1:0] DATA_1,
  input  logic [DW-1:0] DATA_2,
  output logic          GNT_0,
  output logic          GNT_1,
  output logic          GNT_2,
  output logic [AW-1:0] N_REG,
  output logic [DW-1:0] REG_IN,
  output logic          REG_WEN,
  output logic [1:0]    LAST_GNT
);

  // Handshake: REQ_i acts as valid and GNT_i as ready. A source holds REQ_i, NREG_i and DATA_i
  // until it samples GNT_i = 1 at a rising edge. Ungranted requests simply persist.
  logic [1:0]    ptr;
  logic [2:0]    req;
  logic [2:0]    gnt;
  logic [1:0]    win;
  logic          win_vld;
  logic [2:0]    sum;
  logic [AW-1:0] win_nreg;
  logic [DW-1:0] win_data;

  assign req = {REQ_2, REQ_1, REQ_0};

  // Scan from ptr upward (mod 3); the first requester found wins.
  always_comb begin
    gnt     = 3'b000;
    win     = 2'd0;
    win_vld = 1'b0;
    sum     = 3'd0;
    if (!RESET && !STALL) begin
      for (int i = 0; i < 3; i++) begin
        sum = {1'b0, ptr} + 3'(i);
        if (sum >= 3'd3) sum = sum - 3'd3;
        if (!win_vld && req[sum[1:0]]) begin
          win_vld = 1'b1;
          win     = sum[1:0];
        end
      end
      if (win_vld) gnt[win] = 1'b1;
    end
  end

  assign GNT_0 = gnt[0];
  assign GNT_1 = gnt[1];
  assign GNT_2 = gnt[2];

  always_comb begin
    win_nreg = NREG_0;
    win_data = DATA_0;
    case (win)
      2'd1: begin
        win_nreg = NREG_1;
        win_data = DATA_1;
      end
      2'd2: begin
        win_nreg = NREG_2;
        win_data = DATA_2;
      end
      default: begin
        win_nreg = NREG_0;
        win_data = DATA_0;
      end
    endcase
  end

  always_ff @(posedge CLK_WB) begin
    if (RESET) begin
      ptr      <= 2'd0;
      N_REG    <= '0;
      REG_IN   <= '0;
      REG_WEN  <= 1'b0;
      LAST_GNT <= 2'b11;
    end else begin
      REG_WEN <= win_vld;
      if (win_vld) begin
        N_REG    <= win_nreg;
        REG_IN   <= win_data;
        LAST_GNT <= win;
`ifdef WB_FIXED_PRIO_EN
        ptr      <= 2'd0;
`else
        ptr      <= (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a vector table of grant/LAST_GNT expectations, with a write scoreboard
// plus hand-written sequences for same-destination ordering and single-source writes.
module tb_wb_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          CLK_WB = 1'b0;
  logic          RESET;
  logic          STALL;
  logic [2:0]    req;
  logic [AW-1:0] nreg [3];
  logic [DW-1:0] data [3];
  logic          GNT_0, GNT_1, GNT_2;
  logic [AW-1:0] N_REG;
  logic [DW-1:0] REG_IN;
  logic          REG_WEN;
  logic [1:0]    LAST_GNT;

  wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .CLK_WB(CLK_WB), .RESET(RESET), .STALL(STALL),
    .REQ_0(req[0]), .REQ_1(req[1]), .REQ_2(req[2]),
    .NREG_0(nreg[0]), .NREG_1(nreg[1]), .NREG_2(nreg[2]),
    .DATA_0(data[0]), .DATA_1(data[1]), .DATA_2(data[2]),
    .GNT_0(GNT_0), .GNT_1(GNT_1), .GNT_2(GNT_2),
    .N_REG(N_REG), .REG_IN(REG_IN), .REG_WEN(REG_WEN), .LAST_GNT(LAST_GNT)
  );

  // Clock and reset
  always #5 CLK_WB = ~CLK_WB;

  typedef struct {
    logic       rst;
    logic       stall;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] last;
  } vec_t;

  vec_t                vecs [$];
  logic [AW+DW-1:0]    exp_q [$];
  logic [DW-1:0]       rf [8];
  logic [2:0]          held = 3'b000;
  logic                rand_data = 1'b1;
  int                  checks = 0;
  int                  failures = 0;

  // Register-file model fed by the DUT write port.
  always @(posedge CLK_WB) if (REG_WEN) rf[N_REG] <= REG_IN;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic stall, input logic [2:0] r,
                              input logic [2:0] g, input logic [1:0] l);
    vec_t v;
    v.rst = rst; v.stall = stall; v.req = r; v.gnt = g; v.last = l;
    return v;
  endfunction

  // Driver: one cycle of stimulus, grant check, then scoreboard check of the registered write.
  task automatic step(input logic rst, input logic stall, input logic [2:0] r,
                      input logic [2:0] eg, input logic [1:0] el, input string nm);
    logic [AW+DW-1:0] item;
    logic             exp_wen;
    for (int i = 0; i < 3; i++) begin
      if (rand_data && (!req[i] || held[i])) begin
        nreg[i] = AW'($urandom_range(0, 7));
        data[i] = DW'($urandom_range(0, 65535));
      end
    end
    RESET = rst;
    STALL = stall;
    req   = r;
    #2;
    chk({nm, "_gnt"}, {29'd0, GNT_2, GNT_1, GNT_0}, {29'd0, eg});
    held = eg;
    for (int i = 0; i < 3; i++)
      if (eg[i]) exp_q.push_back({nreg[i], data[i]});
    @(posedge CLK_WB);
    #1;
    exp_wen = (exp_q.size() != 0);
    chk({nm, "_wen"}, {31'd0, REG_WEN}, {31'd0, exp_wen});
    if (exp_wen) begin
      item = exp_q.pop_front();
      if (REG_WEN) chk({nm, "_write"}, {13'd0, N_REG, REG_IN}, {13'd0, item});
    end
    chk({nm, "_last"}, {30'd0, LAST_GNT}, {30'd0, el});
  endtask

  initial begin
`ifdef WB_FIXED_PRIO_EN
    vecs.push_back(mk(0, 0, 3'b111, 3'b001, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b001, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b001, 2'd0));
    vecs.push_back(mk(0, 0, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(0, 1, 3'b100, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 3'b100, 3'b100, 2'd2));
    vecs.push_back(mk(0, 0, 3'b011, 3'b001, 2'd0));
    vecs.push_back(mk(1, 0, 3'b011, 3'b000, 2'd3));
    vecs.push_back(mk(0, 0, 3'b110, 3'b010, 2'd1));
    vecs.push_back(mk(0, 0, 3'b101, 3'b001, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b001, 2'd0));
`else
    vecs.push_back(mk(0, 0, 3'b111, 3'b001, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b010, 2'd1));
    vecs.push_back(mk(0, 0, 3'b111, 3'b100, 2'd2));
    vecs.push_back(mk(0, 0, 3'b111, 3'b001, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b010, 2'd1));
    vecs.push_back(mk(0, 0, 3'b111, 3'b100, 2'd2));
    vecs.push_back(mk(0, 0, 3'b000, 3'b000, 2'd2));
    vecs.push_back(mk(0, 1, 3'b100, 3'b000, 2'd2));
    vecs.push_back(mk(0, 1, 3'b100, 3'b000, 2'd2));
    vecs.push_back(mk(0, 1, 3'b100, 3'b000, 2'd2));
    vecs.push_back(mk(0, 0, 3'b100, 3'b100, 2'd2));
    vecs.push_back(mk(0, 0, 3'b011, 3'b001, 2'd0));
    vecs.push_back(mk(1, 0, 3'b011, 3'b000, 2'd3));
    vecs.push_back(mk(0, 0, 3'b011, 3'b001, 2'd0));
    vecs.push_back(mk(0, 0, 3'b011, 3'b010, 2'd1));
    vecs.push_back(mk(0, 0, 3'b101, 3'b100, 2'd2));
    vecs.push_back(mk(0, 0, 3'b110, 3'b010, 2'd1));
    vecs.push_back(mk(0, 0, 3'b011, 3'b001, 2'd0));
    vecs.push_back(mk(0, 1, 3'b111, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b010, 2'd1));
`endif

    // Reset state, with every request high so GNT gating by RESET is exercised.
    RESET = 1'b1;
    STALL = 1'b0;
    req   = 3'b111;
    for (int i = 0; i < 3; i++) begin
      nreg[i] = '0;
      data[i] = '0;
    end
    repeat (2) @(posedge CLK_WB);
    #1;
    chk("rst_gnt", {29'd0, GNT_2, GNT_1, GNT_0}, 32'd0);
    chk("rst_nreg", {29'd0, N_REG}, 32'd0);
    chk("rst_regin", {16'd0, REG_IN}, 32'd0);
    chk("rst_wen", {31'd0, REG_WEN}, 32'd0);
    chk("rst_last", {30'd0, LAST_GNT}, 32'd3);
    req = 3'b000;

    for (int v = 0; v < vecs.size(); v++)
      step(vecs[v].rst, vecs[v].stall, vecs[v].req, vecs[v].gnt, vecs[v].last,
           $sformatf("vec%0d", v));

    // Two sources target the same register: the later-granted value must be final.
    step(1, 0, 3'b000, 3'b000, 2'd3, "same_rst");
    rand_data = 1'b0;
    nreg[0] = 3'd2; data[0] = 16'h1111;
    nreg[2] = 3'd2; data[2] = 16'h2222;
    step(0, 0, 3'b101, 3'b001, 2'd0, "same_a");
    step(0, 0, 3'b100, 3'b100, 2'd2, "same_b");
    step(0, 0, 3'b000, 3'b000, 2'd2, "same_idle");
    chk("same_final", {16'd0, rf[2]}, 32'h2222);

    // Single request from source 1 straight after reset.
    step(1, 0, 3'b000, 3'b000, 2'd3, "beef_rst");
    nreg[1] = 3'd5; data[1] = 16'hBEEF;
    step(0, 0, 3'b010, 3'b010, 2'd1, "beef");
    chk("beef_nreg", {29'd0, N_REG}, 32'd5);
    chk("beef_regin", {16'd0, REG_IN}, 32'hBEEF);
    step(0, 0, 3'b000, 3'b000, 2'd1, "beef_idle");

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port between three writeback sources: 0 = ALU result, 1 = memory load, 2 = I/O / link value.
- Arbitrates requests with round-robin priority and returns a same-cycle grant.
- Drives registered N_REG / REG_IN / REG_WEN directly into the register-file write inputs.
- Sits between the execute/memory stages and the register file.

Parameters:
- DW, 16, data width of the write value.
- AW, 3, register index width (8 registers).

Ports:
- CLK_WB  in  1  writeback clock; all state updates on its rising edge.
- RESET  in  1  synchronous reset, active-high.
- STALL  in  1  when 1, no grant is issued this cycle.
- REQ_0, REQ_1, REQ_2  in  1 each  write request from source i.
- NREG_0, NREG_1, NREG_2  in  AW each  destination register index of source i.
- DATA_0, DATA_1, DATA_2  in  DW each  write value of source i.
- GNT_0, GNT_1, GNT_2  out  1 each  combinational grant to source i.
- N_REG  out  AW  registered destination index to the register file.
- REG_IN  out  DW  registered write data to the register file.
- REG_WEN  out  1  registered write enable to the register file.
- LAST_GNT  out  2  index of the most recent winner (3 = none since reset).

Behaviour:
- Clock and reset: one clock, CLK_WB. RESET is synchronous, active-high.
- Reset values: N_REG = 0, REG_IN = 0, REG_WEN = 0, LAST_GNT = 2'b11, round-robin pointer PTR = 0. All GNT outputs are forced to 0 while RESET = 1.
- Handshake:
  - Source i asserts REQ_i with NREG_i / DATA_i stable.
  - It holds all three unchanged until it samples GNT_i = 1 at a rising edge.
  - On the following cycle it may deassert REQ_i or present a new request.
  - The arbiter stores no request state; a request that is not granted simply persists.
- Grant:
  - Computed combinationally from REQ_*, STALL and PTR.
  - Priority order is PTR, PTR+1, PTR+2 (mod 3).
  - At most one GNT is high per cycle.
  - If STALL = 1 or no REQ is high, all GNT = 0.
- Pointer update: on an edge where source k is granted, PTR <= (k+1) mod 3 and LAST_GNT <= k. Otherwise PTR and LAST_GNT hold.
- Output register, 1-cycle latency:
  - On a grant to k: N_REG <= NREG_k, REG_IN <= DATA_k, REG_WEN <= 1.
  - Otherwise REG_WEN <= 0 and N_REG / REG_IN hold their last values.
  - The register file therefore writes at the edge after the cycle following the grant.
- Throughput: one write per cycle maximum. Back-to-back grants to different sources are allowed.
- Same destination index from two sources in one cycle: no special handling. The winner writes first and the loser writes in a later cycle, so the loser's value is final.
- STALL asserted while a request is pending: the request waits. REG_WEN falls to 0 on the next edge. PTR is unchanged.
- Reset mid-operation: any pending grant is dropped, REG_WEN = 0 on the next cycle and PTR returns to 0. Sources must re-present their requests after reset.
- Single requester: granted every cycle it requests, with no idle bubbles.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority 0 > 1 > 2. PTR is not used and is held at 0. LAST_GNT still updates.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset, then REQ_1 = 1, NREG_1 = 3'd5, DATA_1 = 16'hBEEF -> GNT_1 = 1 in the same cycle; next cycle REG_WEN = 1, N_REG = 5, REG_IN = 16'hBEEF; LAST_GNT = 1.
- All three REQ held high for 6 cycles from reset -> grant sequence 0, 1, 2, 0, 1, 2; REG_WEN = 1 continuously from cycle 2.
- REQ_0 and REQ_2 both target NREG = 3'd2 with DATA 16'h1111 / 16'h2222, PTR = 0 -> writes occur in order 16'h1111 then 16'h2222; final register value 16'h2222.
- STALL = 1 for 3 cycles with REQ_2 high -> GNT all 0 and REG_WEN = 0. On STALL = 0, GNT_2 = 1 and the write follows one cycle later.
- RESET pulsed one cycle while REQ_0 and REQ_1 are active after a prior grant to 0 -> GNT = 0 during reset. Next cycle REG_WEN = 0, LAST_GNT = 3, and the next grant goes to source 0 (PTR = 0).
- With WB_FIXED_PRIO_EN defined and all REQ held high -> GNT_0 every cycle; sources 1 and 2 are never granted.
